float_cmp: RTL
==============

# float_cmp

Parametrised, synthesizable IEEE-754 comparator with AXI-Stream operand, opcode and result channels. It replaces the fixed less-than-only, simulation-only compare unit with:
- selectable width (binary32/binary64);
- six predicates plus unordered;
- NaN/signed-zero exception flags;
- configurable pipeline depth with correct backpressure.

It sits in the FP execution cluster beside the add/mul units and feeds branch/select logic.

## Interface
- SIZE, 64, operand width; legal values 32 or 64 only; elaboration error otherwise.
- LATENCY, 3, cycles from accepted transfer to m_axis_result_tvalid; legal range 1..8.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_a_tdata  in  SIZE  operand A.
- s_axis_a_tvalid  in  1  A valid.
- s_axis_a_tready  out  1  A ready.
- s_axis_b_tdata  in  SIZE  operand B.
- s_axis_b_tvalid  in  1  B valid.
- s_axis_b_tready  out  1  B ready.
- s_axis_op_tdata  in  3  predicate select (cmp_op_t).
- s_axis_op_tvalid  in  1  op valid.
- s_axis_op_tready  out  1  op ready.
- m_axis_result_tdata  out  8  bit0 result, bit1 unordered, bit2 invalid (sNaN present), bit3 illegal opcode, bits7:4 zero.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream ready.

## Operation
- Join: all_valid = a_tvalid & b_tvalid & op_tvalid. advance = m_axis_result_tready | ~m_axis_result_tvalid. All three treadys = advance & all_valid, identical every cycle; no channel is consumed alone.
- Opcodes: EQ=0, LT=1, LE=2, GT=3, GE=4, NE=5, UN=6, 7 illegal.
- Field split: SIZE=32 gives exp 8 / frac 23; SIZE=64 gives exp 11 / frac 52.
- NaN: exp all-ones and frac≠0. sNaN: NaN with frac MSB=0.
- unordered = either operand NaN.
- Ordered compare:
  - ±0 treated as equal.
  - Same sign: compare {exp,frac} unsigned, reversed when both negative.
  - Opposite signs: negative < positive.
  - Subnormals compared exactly, no flush.
  - ±inf ordinary extremes.
- When unordered: EQ/LT/LE/GT/GE → 0; NE → 1; UN → 1. UN is 0 when ordered.
- invalid = either operand sNaN, regardless of opcode.
- Illegal opcode: result=0, bit3=1, bits1..2 still computed.

## Timing
- Stage 1 registers the computed 4-bit flag word from the accepted operands. Stages 2..LATENCY carry only flags+valid (operands not piped).
- Global stall: all stages advance together when advance=1. A bubble at the output stage is filled while downstream is stalled only because advance includes ~tvalid.
- Throughput: one result per cycle when m_axis_result_tready is held at 1.
- Back-to-back transfers: result order equals acceptance order.
- Stalled with tvalid=1: m_axis_result_tdata and tvalid are held stable until the handshake.
- Ready timing: s_*_tready combinationally depends on m_axis_result_tready and the input tvalids. There is no combinational path from tdata to any ready.
- Reset (aresetn=0 at posedge): every stage valid cleared. Outputs next cycle: m_axis_result_tvalid=0, m_axis_result_tdata=0, all s_*_tready=0 while aresetn=0. In-flight results are discarded.
- Reset mid-stall: same as above; first post-reset acceptance no earlier than the cycle after aresetn returns to 1.

## Structure
- Package float_pkg contains:
  - cmp_op_t enum;
  - result bit-index constants;
  - functions exp_w(SIZE) and frac_w(SIZE).
- Sub-module float_cmp_core: purely combinational, SIZE-parametrised. Takes a, b, op; outputs the 4-bit flag word. float_cmp holds the join, pipeline and handshake.

## Test plan
- SIZE=64, LATENCY=3, ready=1. A=3FF0000000000000 (1.0), B=4000000000000000 (2.0), op=LT → tdata=0x01, exactly 3 cycles after acceptance.
- Same A=B=1.0, op=EQ then op=NE → 0x01 then 0x00. Then A=0000000000000000 (+0), B=8000000000000000 (−0), op=EQ → 0x01.
- A=7FF8000000000000 (qNaN), B=1.0: op=LT → 0x02; op=NE → 0x03. A=7FF0000000000001 (sNaN), op=UN → 0x07.
- A=BFF0000000000000 (−1.0), B=C000000000000000 (−2.0), op=GT → 0x01. Same operands with op=7 → 0x08.
- Stream 10 transfers, drop m_axis_result_tready for 5 cycles mid-stream, and leave b_tvalid low for 2 cycles:
  - no result lost or duplicated, order preserved;
  - tdata stable while stalled;
  - no channel accepted while any tvalid is low.
- SIZE=32, LATENCY=1: A=3F800000, B=40000000, op=LE → 0x01 one cycle later. Assert aresetn=0 with 1 result stalled → tvalid=0 and tdata=0 the next cycle.

Source files
------------

// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  float_pkg : shared types, flag bit positions and field-width helpers
//  Revision  : 1.0
// ============================================================================
package float_pkg;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0,
        CMP_LT = 3'd1,
        CMP_LE = 3'd2,
        CMP_GT = 3'd3,
        CMP_GE = 3'd4,
        CMP_NE = 3'd5,
        CMP_UN = 3'd6
    } cmp_op_t;

    localparam int RES_BIT     = 0;
    localparam int UNORD_BIT   = 1;
    localparam int INVALID_BIT = 2;
    localparam int ILLEGAL_BIT = 3;

    function automatic int exp_w(input int size);
        return (size == 32) ? 8 : 11;
    endfunction

    function automatic int frac_w(input int size);
        return (size == 32) ? 23 : 52;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_cmp_if.sv
`default_nettype none
// ============================================================================
//  float_cmp_if : AXI-Stream operand, opcode and result channels
//  Revision     : 1.0
// ============================================================================
interface float_cmp_if #(
    parameter int SIZE = 64
);
    logic [SIZE-1:0] s_axis_a_tdata;
    logic            s_axis_a_tvalid;
    logic            s_axis_a_tready;
    logic [SIZE-1:0] s_axis_b_tdata;
    logic            s_axis_b_tvalid;
    logic            s_axis_b_tready;
    logic [2:0]      s_axis_op_tdata;
    logic            s_axis_op_tvalid;
    logic            s_axis_op_tready;
    logic [7:0]      m_axis_result_tdata;
    logic            m_axis_result_tvalid;
    logic            m_axis_result_tready;

    modport slave (
        input  s_axis_a_tdata, s_axis_a_tvalid,
        output s_axis_a_tready,
        input  s_axis_b_tdata, s_axis_b_tvalid,
        output s_axis_b_tready,
        input  s_axis_op_tdata, s_axis_op_tvalid,
        output s_axis_op_tready,
        output m_axis_result_tdata, m_axis_result_tvalid,
        input  m_axis_result_tready
    );

    modport master (
        output s_axis_a_tdata, s_axis_a_tvalid,
        input  s_axis_a_tready,
        output s_axis_b_tdata, s_axis_b_tvalid,
        input  s_axis_b_tready,
        output s_axis_op_tdata, s_axis_op_tvalid,
        input  s_axis_op_tready,
        input  m_axis_result_tdata, m_axis_result_tvalid,
        output m_axis_result_tready
    );
endinterface
`default_nettype wire

// File: rtl/float_cmp_core.sv
`default_nettype none
// ============================================================================
//  float_cmp_core : combinational IEEE-754 predicate evaluation -> 4-bit flags
//  Revision       : 1.0
// ============================================================================
module float_cmp_core
    import float_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  wire logic [SIZE-1:0] a_i,
    input  wire logic [SIZE-1:0] b_i,
    input  wire logic [2:0]      op_i,
    output logic      [3:0]      flags_o
);
    localparam int EW = exp_w(SIZE);
    localparam int FW = frac_w(SIZE);

    logic          a_sign, b_sign;
    logic [EW-1:0] a_exp, b_exp;
    logic [FW-1:0] a_frac, b_frac;
    logic [SIZE-2:0] a_mag, b_mag;
    logic a_nan, b_nan, a_snan, b_snan, unord, both_zero, eq, lt, gt, res, illegal;

    assign a_sign = a_i[SIZE-1];
    assign b_sign = b_i[SIZE-1];
    assign a_exp  = a_i[SIZE-2 -: EW];
    assign b_exp  = b_i[SIZE-2 -: EW];
    assign a_frac = a_i[FW-1:0];
    assign b_frac = b_i[FW-1:0];
    assign a_mag  = a_i[SIZE-2:0];
    assign b_mag  = b_i[SIZE-2:0];

    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_snan = a_nan & ~a_frac[FW-1];
    assign b_snan = b_nan & ~b_frac[FW-1];
    assign unord  = a_nan | b_nan;

    // Sign-magnitude ordering; the two zeros collapse to a single value.
    assign both_zero = (a_mag == '0) && (b_mag == '0);
    assign eq        = both_zero || (a_i == b_i);
    assign lt        = (a_sign != b_sign) ? (a_sign & ~both_zero)
                     : (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));
    assign gt        = ~lt & ~eq;

    always_comb begin
        res     = 1'b0;
        illegal = 1'b0;
        case (op_i)
            CMP_EQ:  res = ~unord & eq;
            CMP_LT:  res = ~unord & lt;
            CMP_LE:  res = ~unord & (lt | eq);
            CMP_GT:  res = ~unord & gt;
            CMP_GE:  res = ~unord & (gt | eq);
            CMP_NE:  res = unord | ~eq;
            CMP_UN:  res = unord;
            default: illegal = 1'b1;
        endcase
        flags_o              = '0;
        flags_o[RES_BIT]     = res;
        flags_o[UNORD_BIT]   = unord;
        flags_o[INVALID_BIT] = a_snan | b_snan;
        flags_o[ILLEGAL_BIT] = illegal;
    end
endmodule
`default_nettype wire

// File: rtl/float_cmp.sv
`default_nettype none
// ============================================================================
//  float_cmp : three-channel join, LATENCY-deep flag pipeline, global stall
//  Revision  : 1.0
// ============================================================================
module float_cmp
    import float_pkg::*;
#(
    parameter int SIZE    = 64,
    parameter int LATENCY = 3
) (
    input wire logic  aclk,
    input wire logic  aresetn,
    float_cmp_if.slave bus
);
    if (SIZE != 32 && SIZE != 64) begin : g_bad_size
        $error("float_cmp: SIZE must be 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("float_cmp: LATENCY must be in 1..8");
    end

    logic             all_valid, advance, accept;
    logic [3:0]       core_flags;
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [3:0]       flags_q [LATENCY];
    logic [3:0]       flags_d [LATENCY];

    float_cmp_core #(.SIZE(SIZE)) u_core (
        .a_i     (bus.s_axis_a_tdata),
        .b_i     (bus.s_axis_b_tdata),
        .op_i    (bus.s_axis_op_tdata),
        .flags_o (core_flags)
    );

    assign all_valid = bus.s_axis_a_tvalid & bus.s_axis_b_tvalid & bus.s_axis_op_tvalid;
    // An empty output slot lets the pipe move even while downstream stalls.
    assign advance   = bus.m_axis_result_tready | ~valid_q[LATENCY-1];
    assign accept    = advance & all_valid & aresetn;

    assign bus.s_axis_a_tready  = accept;
    assign bus.s_axis_b_tready  = accept;
    assign bus.s_axis_op_tready = accept;

    always_comb begin
        valid_d = valid_q;
        flags_d = flags_q;
        if (advance) begin
            valid_d[0] = accept;
            flags_d[0] = core_flags;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                flags_d[i] = flags_q[i-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= '0;
            flags_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign bus.m_axis_result_tvalid = valid_q[LATENCY-1];
    assign bus.m_axis_result_tdata  = {4'b0000, flags_q[LATENCY-1]};
endmodule
`default_nettype wire
